// File: rtl/uart_cmd_sched.sv
// uart_cmd_sched: dispatches UART commands to NUM_TGT targets, round-robins NUM_EVT event bytes onto the one response path.
// Latency: cmd_rdy->clr_cmd_rdy 1, ->tgt_go 2, tgt_done->send_resp 2; one byte in flight, new work only accepted in IDLE.
module uart_cmd_sched #(
  parameter int          NUM_TGT = 4,
  parameter int          NUM_EVT = 2,
  parameter int          TMO_CYC = 50000,
  parameter logic [7:0]  ACK     = 8'hA5,
  parameter logic [7:0]  NAK     = 8'h5A,
  parameter logic [7:0]  TMO     = 8'hEE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_rdy,
  input  logic [7:0]             cmd,
  input  logic [15:0]            data,
  output logic                   clr_cmd_rdy,
  output logic [NUM_TGT-1:0]     tgt_go,
  output logic [3:0]             tgt_op,
  output logic [15:0]            tgt_data,
  input  logic [NUM_TGT-1:0]     tgt_done,
  input  logic [NUM_EVT-1:0]     evt_req,
  input  logic [8*NUM_EVT-1:0]   evt_byte,
  output logic [NUM_EVT-1:0]     evt_ack,
  output logic                   send_resp,
  output logic [7:0]             resp,
  input  logic                   resp_sent,
  output logic                   busy
);
  localparam int EW = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1;
  localparam int CW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

  typedef enum logic [2:0] {IDLE, DISPATCH, WAIT_DONE, SEND, WAIT_SENT} state_t;

  state_t               state_q, state_d;
  logic [NUM_TGT-1:0]   sel_q, sel_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [EW-1:0]        rr_q, rr_d;
  logic                 evt_turn_q, evt_turn_d;
  logic                 clr_cmd_rdy_q, clr_cmd_rdy_d;
  logic [NUM_TGT-1:0]   tgt_go_q, tgt_go_d;
  logic [3:0]           tgt_op_q, tgt_op_d;
  logic [15:0]          tgt_data_q, tgt_data_d;
  logic [NUM_EVT-1:0]   evt_ack_q, evt_ack_d;
  logic                 send_resp_q, send_resp_d;
  logic [7:0]           resp_q, resp_d;
  logic                 busy_q, busy_d;

  logic [NUM_EVT-1:0]   req_hi;
  logic [EW-1:0]        gnt_idx;
  logic [NUM_EVT-1:0]   gnt_oh;
  logic [7:0]           gnt_byte;
  logic [NUM_TGT-1:0]   cmd_sel;

  // Round-robin: lowest requester at or above rr_q, else lowest overall (wrap).
  always_comb begin
    req_hi   = evt_req & ({NUM_EVT{1'b1}} << rr_q);
    gnt_idx  = '0;
    gnt_oh   = '0;
    gnt_byte = '0;
    cmd_sel  = '0;
    for (int i = NUM_EVT-1; i >= 0; i--) begin
      if (evt_req[i]) gnt_idx = EW'(i);
    end
    for (int i = NUM_EVT-1; i >= 0; i--) begin
      if (req_hi[i]) gnt_idx = EW'(i);
    end
    for (int i = 0; i < NUM_EVT; i++) begin
      gnt_oh[i] = (gnt_idx == EW'(i));
      if (gnt_idx == EW'(i)) gnt_byte = evt_byte[8*i +: 8];
    end
    for (int i = 0; i < NUM_TGT; i++) begin
      cmd_sel[i] = (cmd[7:4] == 4'(i));
    end
  end

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    cnt_d         = cnt_q;
    rr_d          = rr_q;
    evt_turn_d    = evt_turn_q;
    tgt_op_d      = tgt_op_q;
    tgt_data_d    = tgt_data_q;
    resp_d        = resp_q;
    clr_cmd_rdy_d = 1'b0;
    tgt_go_d      = '0;
    evt_ack_d     = '0;
    send_resp_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((|evt_req) && (evt_turn_q || !cmd_rdy)) begin
          evt_ack_d  = gnt_oh;
          resp_d     = gnt_byte;
          rr_d       = (gnt_idx == EW'(NUM_EVT-1)) ? '0 : gnt_idx + 1'b1;
          evt_turn_d = 1'b0;
          state_d    = SEND;
        end else if (cmd_rdy) begin
          clr_cmd_rdy_d = 1'b1;
          sel_d         = cmd_sel;
          tgt_op_d      = cmd[3:0];
          tgt_data_d    = data;
          evt_turn_d    = 1'b1;
          state_d       = DISPATCH;
        end
      end
      // Bad indices also pass through here so NAK keeps the same pacing as a dispatch.
      DISPATCH: begin
        cnt_d = '0;
        if (|sel_q) begin
          tgt_go_d = sel_q;
          state_d  = WAIT_DONE;
        end else begin
          resp_d  = NAK;
          state_d = SEND;
        end
      end
      WAIT_DONE: begin
        if (|(tgt_done & sel_q)) begin
          resp_d  = ACK;
          state_d = SEND;
        end else if (cnt_q == CW'(TMO_CYC-1)) begin
          resp_d  = TMO;
          state_d = SEND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SEND: begin
        send_resp_d = 1'b1;
        state_d     = WAIT_SENT;
      end
      WAIT_SENT: begin
        if (resp_sent) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      cnt_q         <= '0;
      rr_q          <= '0;
      evt_turn_q    <= 1'b0;
      clr_cmd_rdy_q <= 1'b0;
      tgt_go_q      <= '0;
      tgt_op_q      <= '0;
      tgt_data_q    <= '0;
      evt_ack_q     <= '0;
      send_resp_q   <= 1'b0;
      resp_q        <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      cnt_q         <= cnt_d;
      rr_q          <= rr_d;
      evt_turn_q    <= evt_turn_d;
      clr_cmd_rdy_q <= clr_cmd_rdy_d;
      tgt_go_q      <= tgt_go_d;
      tgt_op_q      <= tgt_op_d;
      tgt_data_q    <= tgt_data_d;
      evt_ack_q     <= evt_ack_d;
      send_resp_q   <= send_resp_d;
      resp_q        <= resp_d;
      busy_q        <= busy_d;
    end
  end

  assign clr_cmd_rdy = clr_cmd_rdy_q;
  assign tgt_go      = tgt_go_q;
  assign tgt_op      = tgt_op_q;
  assign tgt_data    = tgt_data_q;
  assign evt_ack     = evt_ack_q;
  assign send_resp   = send_resp_q;
  assign resp        = resp_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_cmd_sched.sv
// Bench for uart_cmd_sched: directed protocol steps plus random traffic scored against a rule-level model.
module tb_uart_cmd_sched;
  localparam int NUM_TGT = 4;
  localparam int NUM_EVT = 2;
  localparam int TMO_CYC = 20;
  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'h5A;
  localparam logic [7:0] TMO = 8'hEE;

  logic clk, rst, cmd_rdy, clr_cmd_rdy, send_resp, resp_sent, busy;
  logic [7:0] cmd, resp;
  logic [15:0] data, tgt_data;
  logic [3:0] tgt_op;
  logic [NUM_TGT-1:0] tgt_go, tgt_done;
  logic [NUM_EVT-1:0] evt_req, evt_ack;
  logic [8*NUM_EVT-1:0] evt_byte;

  uart_cmd_sched #(.NUM_TGT(NUM_TGT), .NUM_EVT(NUM_EVT), .TMO_CYC(TMO_CYC)) dut (
    .clk(clk), .rst(rst), .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data),
    .clr_cmd_rdy(clr_cmd_rdy), .tgt_go(tgt_go), .tgt_op(tgt_op), .tgt_data(tgt_data),
    .tgt_done(tgt_done), .evt_req(evt_req), .evt_byte(evt_byte), .evt_ack(evt_ack),
    .send_resp(send_resp), .resp(resp), .resp_sent(resp_sent), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_clr = 0, n_send = 0, n_go = 0, n_ack = 0;

  always @(posedge clk) begin
    if (clr_cmd_rdy) n_clr <= n_clr + 1;
    if (send_resp)   n_send <= n_send + 1;
    if (|tgt_go)     n_go <= n_go + 1;
    if (|evt_ack)    n_ack <= n_ack + 1;
  end

  // Model state: pending requests, fairness flag and round-robin pointer.
  bit                 cmd_pend, hold_all, m_turn;
  logic [7:0]         pc;
  logic [15:0]        pd;
  int                 pdly, m_rr;
  logic [3:0]         pstray;
  logic [NUM_EVT-1:0] ev_pend;
  logic [7:0]         ev_b [NUM_EVT];
  logic [7:0]         last_resp;
  logic [7:0]         got  [6];
  logic [7:0]         want [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wide"}, {8'h0, tgt_data, resp}, 32'h0);
    chk({tag, "_ctl"}, {19'h0, clr_cmd_rdy, tgt_go, tgt_op, evt_ack, send_resp, busy}, 32'h0);
  endtask

  task automatic new_cmd();
    pc       = {4'($urandom_range(0, 5)), 4'($urandom)};
    pd       = 16'($urandom);
    pdly     = $urandom_range(0, 24);
    pstray   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
    cmd_pend = 1'b1;
  endtask

  // One full transaction from IDLE: predicts which request wins, then checks every step.
  task automatic serve_one(input bit rst_mid);
    bit          do_evt, seen, is_tmo;
    int          g, idx, m, exp_m, n;
    logic [7:0]  exp;
    logic [15:0] oh;
    logic [3:0]  st;
    cmd_rdy  = cmd_pend;
    cmd      = pc;
    data     = pd;
    evt_req  = ev_pend;
    evt_byte = {ev_b[1], ev_b[0]};
    do_evt   = (ev_pend != 0) && (m_turn || !cmd_pend);
    g = -1;
    for (int k = 0; k < NUM_EVT; k++) begin
      int c;
      c = (m_rr + k) % NUM_EVT;
      if (g < 0 && ev_pend[c]) g = c;
    end
    idx = -1; oh = '0; is_tmo = 1'b0; exp = 8'h0; exp_m = 1;
    tick();
    if (do_evt) begin
      chk("evt_ack", evt_ack, 1 << g);
      chk("evt_no_clr", clr_cmd_rdy, 0);
      chk("evt_byte", resp, ev_b[g]);
      exp = ev_b[g];
      if (!hold_all) ev_pend[g] = 1'b0;
      evt_req = ev_pend;
      m_rr    = (g + 1) % NUM_EVT;
      m_turn  = 1'b0;
    end else begin
      chk("clr", clr_cmd_rdy, 1);
      chk("cmd_no_ack", evt_ack, 0);
      if (!hold_all) cmd_pend = 1'b0;
      cmd_rdy = cmd_pend;
      m_turn  = 1'b1;
      idx     = int'(pc[7:4]);
      tick();
      if (idx < NUM_TGT) begin
        oh = 16'(1) << idx;
        chk("tgt_go", tgt_go, oh[3:0]);
        chk("tgt_op", tgt_op, pc[3:0]);
        chk("tgt_data", tgt_data, pd);
        if (pdly <= TMO_CYC - 1) begin
          exp = ACK; exp_m = pdly + 2;
        end else begin
          exp = TMO; exp_m = TMO_CYC + 1; is_tmo = 1'b1;
        end
      end else begin
        chk("nak_no_go", tgt_go, 0);
        exp = NAK;
      end
    end
    st = pstray & ~oh[3:0];
    m = 0; seen = 1'b0;
    while (!seen && m < 60) begin
      tgt_done = '0;
      if (idx >= 0 && idx < NUM_TGT && m == pdly) tgt_done = oh[3:0];
      if (m == 1) tgt_done = tgt_done | st;
      tick();
      m++;
      if (send_resp) seen = 1'b1;
    end
    tgt_done = '0;
    chk("send_seen", seen, 1);
    chk("send_lat", m, exp_m);
    chk("resp", resp, exp);
    last_resp = resp;
    n = is_tmo ? $urandom_range(1, 3) : $urandom_range(0, 3);
    for (int k = 0; k < n; k++) begin
      if (is_tmo) tgt_done = oh[3:0];
      tick();
      chk("send_once", send_resp, 0);
      chk("resp_hold", resp, exp);
    end
    tgt_done = '0;
    if (rst_mid) begin
      rst = 1'b1;
      tick();
      rst = 1'b0; cmd_rdy = 1'b0; evt_req = '0;
      chk_zero("rst_mid");
      m_turn = 1'b0; m_rr = 0; cmd_pend = 1'b0; ev_pend = '0;
    end else begin
      resp_sent = 1'b1;
      tick();
      resp_sent = 1'b0;
      chk("idle_busy", busy, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_clr, s_send, s_go, s_ack;
    rst = 1'b1; cmd_rdy = 1'b0; cmd = '0; data = '0; tgt_done = '0;
    evt_req = '0; evt_byte = '0; resp_sent = 1'b0;
    cmd_pend = 1'b0; hold_all = 1'b0; m_turn = 1'b0; m_rr = 0; pstray = '0;
    ev_pend = '0; ev_b[0] = 8'h0; ev_b[1] = 8'h0; pc = '0; pd = '0; pdly = 0;
    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b0;

    // Command and both events held high: ACK, evt0, ACK, evt1, ACK, evt0.
    want[0] = ACK; want[1] = 8'hB0; want[2] = ACK; want[3] = 8'hB1; want[4] = ACK; want[5] = 8'hB0;
    hold_all = 1'b1; cmd_pend = 1'b1; pc = 8'h20; pd = 16'hBEEF; pdly = 2;
    ev_pend = '1; ev_b[0] = 8'hB0; ev_b[1] = 8'hB1;
    for (int i = 0; i < 6; i++) begin
      serve_one(1'b0);
      got[i] = last_resp;
    end
    for (int i = 0; i < 6; i++) chk("fair_order", got[i], want[i]);
    hold_all = 1'b0; cmd_pend = 1'b0; ev_pend = '0; cmd_rdy = 1'b0; evt_req = '0;

    // Basic dispatch to target 2.
    s_clr = n_clr; s_send = n_send; s_go = n_go;
    pc = 8'h23; pd = 16'h1234; pdly = 5; cmd_pend = 1'b1;
    serve_one(1'b0);
    chk("one_clr", n_clr - s_clr, 1);
    chk("one_send", n_send - s_send, 1);
    chk("one_go", n_go - s_go, 1);

    // Out-of-range target index.
    s_go = n_go;
    pc = 8'h51; pd = 16'h0BAD; pdly = 0; cmd_pend = 1'b1;
    serve_one(1'b0);
    chk("nak_go_cnt", n_go - s_go, 0);

    // Completion on the last cycle before timeout still wins.
    pc = 8'h32; pd = 16'h5555; pdly = TMO_CYC - 1; cmd_pend = 1'b1;
    serve_one(1'b0);
    pc = 8'h31; pd = 16'h6666; pdly = TMO_CYC; cmd_pend = 1'b1;
    serve_one(1'b0);

    // No completion at all, then a late done once idle.
    pc = 8'h10; pd = 16'h7777; pdly = 99; cmd_pend = 1'b1;
    serve_one(1'b0);
    s_send = n_send;
    tgt_done = 4'b0010;
    tick();
    tgt_done = '0;
    tick();
    chk("late_done_busy", busy, 0);
    tick();
    chk("late_done_send", n_send - s_send, 0);

    // Done on another index is ignored.
    pc = 8'h17; pd = 16'hA0A0; pdly = 6; pstray = 4'b0100; cmd_pend = 1'b1;
    serve_one(1'b0);
    pstray = '0;

    // Reset while waiting for the transmitter, then normal traffic.
    pc = 8'h30; pd = 16'hC0DE; pdly = 3; cmd_pend = 1'b1;
    serve_one(1'b1);
    s_clr = n_clr; s_send = n_send; s_go = n_go; s_ack = n_ack;
    repeat (4) tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_pulses", (n_clr - s_clr) + (n_send - s_send) + (n_go - s_go) + (n_ack - s_ack), 0);
    pc = 8'h02; pd = 16'h4321; pdly = 1; cmd_pend = 1'b1;
    serve_one(1'b0);

    // Random mix of commands and events.
    for (int it = 0; it < 30; it++) begin
      if (!cmd_pend && $urandom_range(0, 2) != 0) new_cmd();
      for (int i = 0; i < NUM_EVT; i++) begin
        if (!ev_pend[i] && $urandom_range(0, 2) == 0) begin
          ev_pend[i] = 1'b1;
          ev_b[i]    = 8'($urandom);
        end
      end
      if (!cmd_pend && ev_pend == 0) new_cmd();
      serve_one(1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
